// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the pc, issues one imem request at a time and
// presents {pc, inst, valid} to IF/ID with stall and redirect handling.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        r,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;
    localparam logic [1:0] ST_DROP  = 2'd3;

    logic [1:0]  state_r;
    logic [1:0]  state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic        if_valid_r;
    logic        if_valid_s;
    logic [31:0] if_pc_r;
    logic [31:0] if_pc_s;
    logic [31:0] if_inst_r;
    logic [31:0] if_inst_s;
    logic        outstanding_s;

    // Next-state and datapath selection; redirect overrides stall and rvalid.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        if_valid_s    = if_valid_r;
        if_pc_s       = if_pc_r;
        if_inst_s     = if_inst_r;
        outstanding_s = 1'b0;
        if (redirect) begin
            pc_s       = redirect_pc & 32'hFFFF_FFFC;
            if_valid_s = 1'b0;
            if_inst_s  = NOP_INST;
            // A request still in flight after this edge must have its response dropped.
            case (state_r)
                ST_FETCH: outstanding_s = imem_ack;
                ST_WAIT:  outstanding_s = ~imem_rvalid;
                ST_DROP:  outstanding_s = ~imem_rvalid;
                default:  outstanding_s = 1'b0;
            endcase
            if (outstanding_s) begin
                state_s = ST_DROP;
            end else begin
                state_s = ST_FETCH;
            end
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_ack) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if_valid_s = 1'b1;
                        if_pc_s    = pc_r;
                        if_inst_s  = imem_rdata;
                        pc_s       = pc_r + 32'd4;
                        state_s    = ST_OUT;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_OUT: begin
                    if (!stall) begin
                        if_valid_s = 1'b0;
                        if_inst_s  = NOP_INST;
                        state_s    = ST_FETCH;
                    end else begin
                        state_s = ST_OUT;
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_DROP;
                    end
                end
                default: begin
                    state_s = ST_FETCH;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC;
            if_valid_r <= 1'b0;
            if_pc_r    <= 32'h0000_0000;
            if_inst_r  <= NOP_INST;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            if_valid_r <= if_valid_s;
            if_pc_r    <= if_pc_s;
            if_inst_r  <= if_inst_s;
        end
    end

    // Request is gated by reset so it drops the instant reset asserts.
    assign imem_req  = (state_r == ST_FETCH) && !r;
    assign imem_addr = pc_r;
    assign if_valid  = if_valid_r;
    assign if_pc     = if_pc_r;
    assign if_inst   = if_inst_r;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues one instruction-memory request at a time over a req/ack and rvalid handshake with variable latency.
- Presents {pc, instruction, valid} to IF/ID.
- Handles downstream stall and branch/jump redirect, including discarding an in-flight response that a redirect has made stale.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, instruction driven on if_inst when if_valid=0 (addi x0,x0,0)

Ports:
clk  input  1  clock; all state updates on the rising edge
r  input  1  asynchronous, active-high reset
stall  input  1  downstream cannot accept; the held output must not change
redirect  input  1  taken branch/jump from a later stage
redirect_pc  input  32  redirect target; bits [1:0] are forced to 0 internally
imem_req  output  1  request valid
imem_addr  output  32  request address (current pc)
imem_ack  input  1  memory accepts the request this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  32  response instruction
if_valid  output  1  if_pc/if_inst hold a valid fetched instruction
if_pc  output  32  pc of the presented instruction
if_inst  output  32  presented instruction

Behaviour:
- States: FETCH, WAIT, OUT, DROP. At most one memory request is outstanding at any time.
- Reset (r=1, asynchronous):
  - state=FETCH, pc=RESET_PC
  - if_valid=0, if_pc=0, if_inst=NOP_INST
  - imem_req=0 while r is high
  - Reset mid-request abandons that request. A later imem_rvalid seen in FETCH is ignored.
- imem_req=1 only in FETCH. imem_addr=pc in all states.
- FETCH:
  - imem_ack=1 -> WAIT.
  - Otherwise stay in FETCH, holding req and addr stable.
- WAIT:
  - imem_rvalid=1 -> if_valid<=1, if_pc<=pc, if_inst<=imem_rdata, pc<=pc+4, go to OUT.
  - Latency from rvalid to if_valid is 1 cycle.
- OUT:
  - Transfer completes on a rising edge with if_valid=1 and stall=0. Then if_valid<=0, if_inst<=NOP_INST, go to FETCH.
  - With stall=1, all outputs hold unchanged for any number of cycles.
- Throughput: at most one instruction per 3 cycles with a 1-cycle memory (FETCH, WAIT, OUT).
- Redirect has the highest priority in every state and wins over stall and rvalid:
  - pc<=redirect_pc & ~3, if_valid<=0, if_inst<=NOP_INST.
  - Next state:
    - DROP if a request is outstanding after this edge, i.e. (FETCH and imem_ack=1) or (WAIT and imem_rvalid=0).
    - FETCH otherwise: FETCH without ack, WAIT with rvalid=1 (data discarded), OUT, or DROP with rvalid=1.
  - A redirect while in DROP with rvalid=0 updates pc and stays in DROP.
- DROP:
  - imem_req=0.
  - The first imem_rvalid is discarded and never reaches the outputs; go to FETCH.
- Boundary cases:
  - PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  - imem_rvalid outside WAIT/DROP is ignored.
  - stall has no effect in FETCH, WAIT or DROP.

Test Plan:
1. Reset then release, memory with ack same cycle and rvalid 1 cycle later, rdata=0x00500093 at pc 0 and 0x00A00113 at pc 4, stall=0 -> imem_addr 0 then 4. if_valid pulses with (if_pc=0, if_inst=0x00500093) then (if_pc=4, if_inst=0x00A00113). if_inst=NOP_INST between them.
2. stall=1 for 5 cycles while in OUT with if_pc=8 -> if_valid, if_pc=8 and if_inst are unchanged. imem_req=0 throughout. Fetch of pc 12 starts the cycle after stall drops.
3. Redirect to 0x100 while in WAIT with the memory returning 3 cycles later (rdata=0xDEADBEEF) -> DROP state, 0xDEADBEEF never appears on if_inst. Next imem_addr=0x100 with imem_req=1.
4. redirect=1 and stall=1 in the same cycle while in OUT (redirect_pc=0x203) -> if_valid=0 next cycle, imem_addr=0x200, state FETCH.
5. Redirect to 0xFFFF_FFFC, fetch completes -> the following imem_addr is 0x0000_0000.
6. Assert r asynchronously mid-WAIT -> if_valid=0 and imem_req=0 immediately. After release, imem_addr=RESET_PC. A stale imem_rvalid arriving during reset or in FETCH produces no if_valid.
